seq_mul_shift_add: RTL

- Iterative shift-add multiplier. Generalised sequential successor to the combinational 32x32 partial-product stage.
- Consumes STEP multiplier bits per clock and accumulates the shifted partial products into a 2*WIDTH accumulator.
- Valid/ready handshake on input and output, so it drops into the datapath where the area of a full partial-product array is not justified.

---
 rtl/seq_mul_shift_add.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seq_mul_shift_add.sv
// Purpose : iterative shift-add multiplier, STEP multiplier bits retired per clock.
// Latency : accept on edge N -> out_valid after edge N+CYCLES (fixed, no early exit).
// Backpres: product held in DONE until out_ready; in_ready low from accept until after the output handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (accepted only in IDLE)
//   in1, in2            multiplicand, multiplier (WIDTH bits)
//   out_valid/out_ready product handshake
//   product             2*WIDTH result, driven straight from the accumulator register
//   busy                high while iterating
//   is_signed           two's-complement mode select (only with MUL_SIGNED_EN defined)
//
// Optional feature macro: MUL_SIGNED_EN (signed mode: magnitudes are multiplied,
// the accumulator is negated in the final BUSY cycle when the operand signs differ).
// STEP must divide WIDTH (1, 2, 4 or 8 supported); WIDTH must be at least 2.
module seq_mul_shift_add #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
`ifdef MUL_SIGNED_EN
  ,
  input  logic               is_signed
`endif
);

  localparam int CYCLES = WIDTH / STEP;
  localparam int CW     = $clog2(CYCLES + 1);
  localparam int PW     = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   acc_nxt;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] op1, op2;
  logic            accept;
  logic            last;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        // cnt==1 marks the final update; DONE follows on the same edge
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- operand conditioning ----------------
`ifdef MUL_SIGNED_EN
  logic neg;
  logic sign_x;
  always_comb begin
    // magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude (e.g. 0x80000000 -> 0x80000000)
    op1    = (is_signed && in1[WIDTH-1]) ? ((~in1) + WIDTH'(1)) : in1;
    op2    = (is_signed && in2[WIDTH-1]) ? ((~in2) + WIDTH'(1)) : in2;
    sign_x = is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
  end
`else
  always_comb begin
    op1 = in1;
    op2 = in2;
  end
`endif

  // ---------------- partial-product accumulate ----------------
  always_comb begin
    acc_sum = acc;
    for (int k = 0; k < STEP; k++) begin
      if (mplr[k]) begin
        acc_sum = acc_sum + (mcand << k);
      end
    end
`ifdef MUL_SIGNED_EN
    acc_nxt = (last && neg) ? ((~acc_sum) + PW'(1)) : acc_sum;
`else
    acc_nxt = acc_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
`ifdef MUL_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= {{WIDTH{1'b0}}, op1};
      mplr  <= op2;
      acc   <= '0;
      cnt   <= CW'(CYCLES);
`ifdef MUL_SIGNED_EN
      neg   <= sign_x;
`endif
    end else if (state == BUSY) begin
      acc   <= acc_nxt;
      mcand <= mcand << STEP;
      mplr  <= mplr >> STEP;
      cnt   <= cnt - CW'(1);
    end
  end

  assign product = acc;

endmodule
